// File: rtl/uart_freq_cmd.sv
// uart_freq_cmd: 8N1 UART receiver feeding a framed command parser that updates a 32-bit divider value.
// Packet: 0xA5, four data bytes MSB first, XOR checksum; byte gaps are bounded by TIMEOUT_CLKS.
module uart_freq_cmd #(
  parameter int          CLKS_PER_BIT = 217,
  parameter logic [31:0] FREQ_DEFAULT = 32'd2500000,
  parameter int          TIMEOUT_CLKS = 25000
) (
  input  logic        CLK_25MHZ,
  input  logic        RSTN,
  input  logic        UART_RX,
  output logic [31:0] freq_val,
  output logic        freq_upd,
  output logic        frame_err,
  output logic        cmd_err
);
  localparam int MAXC = (CLKS_PER_BIT > TIMEOUT_CLKS) ? CLKS_PER_BIT : TIMEOUT_CLKS;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CLKS - 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  localparam logic [2:0] P_SYNC = 3'd0;
  localparam logic [2:0] P_D3   = 3'd1;
  localparam logic [2:0] P_D0   = 3'd4;
  localparam logic [2:0] P_CHK  = 3'd5;

  logic          rx_s1_q, rx_s2_q;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_wait_q, stop_wait_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    p_st_q, p_st_d;
  logic [31:0]   data_q, data_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]   freq_q, freq_d;
  logic          upd_q, upd_d;
  logic          cmd_err_q, cmd_err_d;
  logic [7:0]    chk;
  logic          rx;

  assign rx  = rx_s2_q;
  assign chk = data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];

  always_comb begin
    rx_st_d      = rx_st_q;
    clk_cnt_d    = clk_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    stop_wait_d  = stop_wait_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        rx_st_d   = rx ? S_IDLE : S_START;
      end
      S_START:
        if (clk_cnt_q == HALF) begin
          clk_cnt_d = '0;
          rx_st_d   = rx ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          rx_st_d   = (bit_cnt_q == 3'd7) ? S_STOP : S_DATA;
        end
      default:
        // A bad stop bit reports once, then waits for the line to return high.
        if (stop_wait_q) begin
          clk_cnt_d   = '0;
          stop_wait_d = !rx;
          rx_st_d     = rx ? S_IDLE : S_STOP;
        end else if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d    = '0;
          byte_valid_d = rx;
          frame_err_d  = !rx;
          stop_wait_d  = !rx;
          rx_st_d      = rx ? S_IDLE : S_STOP;
        end
    endcase
  end

  always_comb begin
    p_st_d    = p_st_q;
    data_d    = data_q;
    to_cnt_d  = '0;
    freq_d    = freq_q;
    upd_d     = 1'b0;
    cmd_err_d = 1'b0;
    if (byte_valid_q) begin
      if (p_st_q == P_SYNC) begin
        p_st_d = (shift_q == 8'hA5) ? P_D3 : P_SYNC;
        data_d = '0;
      end else if (p_st_q == P_CHK) begin
        p_st_d    = P_SYNC;
        data_d    = '0;
        upd_d     = (shift_q == chk) && (data_q != '0);
        cmd_err_d = !upd_d;
        freq_d    = upd_d ? data_q : freq_q;
      end else begin
        data_d = {data_q[23:0], shift_q};
        p_st_d = (p_st_q <= P_D0) ? p_st_q + 3'd1 : P_SYNC;
      end
    end else if (p_st_q != P_SYNC) begin
      // A framing error aborts silently; only a timeout counts as a command error.
      if (frame_err_q || to_cnt_q == TO_LAST) begin
        p_st_d    = P_SYNC;
        data_d    = '0;
        cmd_err_d = !frame_err_q;
      end else
        to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_25MHZ or negedge RSTN)
    if (!RSTN) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_st_q      <= S_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      stop_wait_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      p_st_q       <= P_SYNC;
      data_q       <= '0;
      to_cnt_q     <= '0;
      freq_q       <= FREQ_DEFAULT;
      upd_q        <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      rx_s1_q      <= UART_RX;
      rx_s2_q      <= rx_s1_q;
      rx_st_q      <= rx_st_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      stop_wait_q  <= stop_wait_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      p_st_q       <= p_st_d;
      data_q       <= data_d;
      to_cnt_q     <= to_cnt_d;
      freq_q       <= freq_d;
      upd_q        <= upd_d;
      cmd_err_q    <= cmd_err_d;
    end

  assign freq_val  = freq_q;
  assign freq_upd  = upd_q;
  assign frame_err = frame_err_q;
  assign cmd_err   = cmd_err_q;
endmodule

// File: doc/uart_freq_cmd.md
UART_FREQ_CMD -- requirements
Module: uart_freq_cmd

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clocks per UART bit (25 MHz / 115200).
REQ-002 SHALL have parameter FREQ_DEFAULT, default 32'd2500000, meaning the freq_val value after reset.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 25000, meaning the maximum gap in clocks between bytes inside a packet (1 ms).
REQ-004 SHALL have port CLK_25MHZ, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port RSTN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port UART_RX, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port freq_val, output, 32 bits: divider value consumed by the blink stage.
REQ-008 SHALL have port freq_upd, output, 1 bit: single-cycle pulse when freq_val takes a new value.
REQ-009 SHALL have port frame_err, output, 1 bit: single-cycle pulse on a stop-bit error.
REQ-010 SHALL have port cmd_err, output, 1 bit: single-cycle pulse on a rejected or aborted packet.

Function
REQ-011 SHALL pass UART_RX through a 2-FF synchronizer before any other use.
REQ-012 SHALL implement the RX FSM with states IDLE, START, DATA and STOP.
- IDLE -> START when synced rx = 0.
REQ-013 SHALL, in START, resample rx at count CLKS_PER_BIT/2 (integer division).
- rx = 0: go to DATA.
- rx = 1: treat as a glitch and return to IDLE with no output.
REQ-014 SHALL, in DATA, sample every CLKS_PER_BIT clocks, mid-bit, 8 bits LSB first, then go to STOP.
REQ-015 SHALL, in STOP, sample rx after CLKS_PER_BIT clocks.
- rx = 1: pulse internal byte_valid for 1 cycle and go to IDLE.
- rx = 0: pulse frame_err, discard the byte, and stay in STOP until rx = 1, then go to IDLE.
REQ-016 SHALL implement the packet parser with states P_SYNC, P_D3, P_D2, P_D1, P_D0 and P_CHK.
- Packet format: 0xA5, then 4 data bytes MSB first, then a checksum byte.
REQ-017 SHALL, in P_SYNC, move to P_D3 on byte 0xA5 and silently ignore any other byte.
REQ-018 SHALL, in P_CHK, compare the received byte against the XOR of the 4 data bytes.
- Match and value != 0: freq_val <= value and freq_upd = 1 in the same cycle, exactly 1 cycle after byte_valid.
- Mismatch or value == 0: pulse cmd_err and leave freq_val unchanged.
- Parser returns to P_SYNC in either case.
REQ-019 SHALL count clocks since the last byte_valid in every parser state except P_SYNC.
- When the count reaches TIMEOUT_CLKS: return to P_SYNC, pulse cmd_err, discard partial data.
REQ-020 SHALL give byte_valid priority over timeout when both occur in the same cycle; the byte is consumed and the counter is cleared.
REQ-021 SHALL, when frame_err pulses while the parser is outside P_SYNC, abort to P_SYNC with frame_err only and no cmd_err.
REQ-022 SHALL hold freq_val stable between updates; freq_upd, frame_err and cmd_err SHALL each be high for exactly one cycle per event.
REQ-023 SHALL use counters wide enough for max(CLKS_PER_BIT, TIMEOUT_CLKS) with no wrap-around during a bit or a timeout window.

Reset
REQ-024 SHALL, while RSTN = 0, immediately force the following regardless of clock:
- freq_val = FREQ_DEFAULT;
- freq_upd = frame_err = cmd_err = 0;
- synchronizer flops = 1;
- RX FSM = IDLE, parser = P_SYNC;
- all counters and data registers = 0.
REQ-025 SHALL discard any packet or byte in progress when reset is asserted mid-operation; bytes arriving after release SHALL need a fresh 0xA5.

Verification
REQ-026 SHALL verify: send A5 00 98 96 80 8E at 115200 baud -> freq_val = 10000000, exactly one freq_upd pulse, no error pulses.
REQ-027 SHALL verify: send A5 00 98 96 80 8F -> one cmd_err pulse, freq_val stays 2500000, no freq_upd.
REQ-028 SHALL verify: second data byte sent with stop bit = 0 -> one frame_err pulse, parser back in P_SYNC; a following valid packet is accepted normally.
REQ-029 SHALL verify: A5 00 98 followed by a 2 ms idle gap -> cmd_err at TIMEOUT_CLKS after the last byte, freq_val unchanged.
REQ-030 SHALL verify: RSTN pulsed low after A5 00 98 96 of a 10000000 packet that previously updated freq_val -> freq_val = 2500000 asynchronously; the trailing 80 8E produce no update.
REQ-031 SHALL verify two edge cases:
- 3 µs low glitch on UART_RX -> no byte and no pulses.
- A5 00 00 00 00 00 -> cmd_err and no update.
